operand_bypass_unit: RTL and testbench

//  Parametrised operand forwarding and hazard unit for the ID->EX boundary of the MIPS pipeline.

---
 rtl/operand_bypass_unit_pkg.sv | 13 +
 rtl/operand_bypass_unit_if.sv | 42 ++++
 rtl/operand_bypass_unit_src_sel.sv | 42 ++++
 rtl/operand_bypass_unit.sv | 80 ++++++++
 tb/tb_operand_bypass_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/operand_bypass_unit_pkg.sv
// bypass_pkg: tag entry type and stage constants shared by the operand bypass unit
package bypass_pkg;
   localparam int MAX_AW = 8;
   localparam logic [MAX_AW-1:0] REG_ZERO = '0;
   localparam int STG_EXMEM = 0;
   localparam int STG_MEMWB = 1;
   typedef struct packed {
      logic              valid;
      logic              we;
      logic              is_load;
      logic [MAX_AW-1:0] addr;
   } tag_t;
endpackage

// File: rtl/operand_bypass_unit_if.sv
// operand_bypass_unit_if: decode/EX bus of the bypass unit
// FWD_STATS_EN adds the stall and forward statistic counters
interface operand_bypass_unit_if #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2
);
   logic                      flush;
   logic                      id_valid;
   logic [NUM_SRC*REG_AW-1:0] id_src_addr;
   logic [NUM_SRC*DATA_W-1:0] id_src_data;
   logic [DATA_W-1:0]         id_imm;
   logic                      id_alusrc;
   logic [REG_AW-1:0]         id_dst_addr;
   logic                      id_dst_we;
   logic                      id_is_load;
   logic [DEPTH*DATA_W-1:0]   stage_wdata;
   logic                      stall;
   logic                      ex_valid;
   logic [NUM_SRC*DATA_W-1:0] ex_op;
`ifdef FWD_STATS_EN
   logic [31:0]               stat_stall_cnt;
   logic [31:0]               stat_fwd_cnt;
`endif
   modport master (
      output flush, id_valid, id_src_addr, id_src_data, id_imm, id_alusrc,
             id_dst_addr, id_dst_we, id_is_load, stage_wdata,
      input  stall, ex_valid, ex_op
`ifdef FWD_STATS_EN
      , input stat_stall_cnt, stat_fwd_cnt
`endif
   );
   modport slave (
      input  flush, id_valid, id_src_addr, id_src_data, id_imm, id_alusrc,
             id_dst_addr, id_dst_we, id_is_load, stage_wdata,
      output stall, ex_valid, ex_op
`ifdef FWD_STATS_EN
      , output stat_stall_cnt, stat_fwd_cnt
`endif
   );
endinterface

// File: rtl/operand_bypass_unit_src_sel.sv
// bypass_src_sel: youngest-match forwarding mux and load-use hazard flag for one source operand
module bypass_src_sel
   import bypass_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int DEPTH      = 2,
   parameter int LOAD_STAGE = 1,
   parameter bit IS_LAST    = 1'b0
) (
   input  tag_t [DEPTH-1:0]        i_tags,
   input  logic [REG_AW-1:0]       i_src_addr,
   input  logic [DATA_W-1:0]       i_src_data,
   input  logic [DATA_W-1:0]       i_imm,
   input  logic                    i_alusrc,
   input  logic [DEPTH*DATA_W-1:0] i_stage_wdata,
   output logic [DATA_W-1:0]       o_data,
   output logic                    o_hazard,
   output logic                    o_fwd
);
   logic              w_hit;
   logic              w_ld;
   logic              w_imm;
   logic [DATA_W-1:0] w_sel;
   // oldest-to-youngest scan so the youngest match overwrites
   always_comb begin
      w_hit = 1'b0;
      w_ld  = 1'b0;
      w_sel = '0;
      for (int i = DEPTH-1; i >= 0; i--)
         if (i_tags[i].valid && i_tags[i].we && i_tags[i].addr == MAX_AW'(i_src_addr) &&
             MAX_AW'(i_src_addr) != REG_ZERO) begin
            w_hit = 1'b1;
            w_ld  = i_tags[i].is_load && (i < LOAD_STAGE);
            w_sel = i_stage_wdata[i*DATA_W +: DATA_W];
         end
   end
   assign w_imm    = IS_LAST && i_alusrc;
   assign o_data   = w_imm ? i_imm : w_hit ? w_sel : i_src_data;
   assign o_hazard = ~w_imm & w_ld;
   assign o_fwd    = ~w_imm & w_hit;
endmodule

// File: rtl/operand_bypass_unit.sv
// operand_bypass_unit: ID->EX tag pipe, operand forwarding, load-use stall and EX operand register
// FWD_STATS_EN adds saturating stall-cycle and forwarded-instruction counters
module operand_bypass_unit
   import bypass_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int NUM_SRC    = 2,
   parameter int DEPTH      = 2,
   parameter int LOAD_STAGE = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   operand_bypass_unit_if.slave bus
);
   tag_t [DEPTH-1:0]          r_tags;
   logic                      r_ex_valid;
   logic [NUM_SRC*DATA_W-1:0] r_ex_op;
   logic [NUM_SRC*DATA_W-1:0] w_op;
   logic [NUM_SRC-1:0]        w_haz;
   logic [NUM_SRC-1:0]        w_fwd;
   logic                      w_stall;
   logic                      w_acc;
   genvar s;
   generate
      for (s = 0; s < NUM_SRC; s++) begin : g_src
         bypass_src_sel #(
            .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH),
            .LOAD_STAGE(LOAD_STAGE), .IS_LAST(s == NUM_SRC-1)
         ) u_sel (
            .i_tags        (r_tags),
            .i_src_addr    (bus.id_src_addr[s*REG_AW +: REG_AW]),
            .i_src_data    (bus.id_src_data[s*DATA_W +: DATA_W]),
            .i_imm         (bus.id_imm),
            .i_alusrc      (bus.id_alusrc),
            .i_stage_wdata (bus.stage_wdata),
            .o_data        (w_op[s*DATA_W +: DATA_W]),
            .o_hazard      (w_haz[s]),
            .o_fwd         (w_fwd[s])
         );
      end
   endgenerate
   assign w_stall      = bus.id_valid & |w_haz;
   assign w_acc        = bus.id_valid & ~w_stall & ~bus.flush;
   assign bus.stall    = w_stall;
   assign bus.ex_valid = r_ex_valid;
   assign bus.ex_op    = r_ex_op;
   // stall and flush both leave a bubble in entry 0
   always_ff @(posedge clk)
      if (!rst_n) begin
         r_tags     <= '0;
         r_ex_valid <= 1'b0;
         r_ex_op    <= '0;
      end else begin
         for (int i = DEPTH-1; i > 0; i--)
            r_tags[i] <= bus.flush ? '0 : r_tags[i-1];
         r_tags[STG_EXMEM] <= w_acc ? tag_t'{valid: 1'b1, we: bus.id_dst_we,
                                             is_load: bus.id_is_load,
                                             addr: MAX_AW'(bus.id_dst_addr)} : '0;
         r_ex_valid <= w_acc;
         r_ex_op    <= w_acc ? w_op : '0;
      end
`ifdef FWD_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_fwd_cnt;
   always_ff @(posedge clk)
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         r_stall_cnt <= r_stall_cnt + 32'(w_stall && ~&r_stall_cnt);
         r_fwd_cnt   <= r_fwd_cnt + 32'(w_acc && |w_fwd && ~&r_fwd_cnt);
      end
   assign bus.stat_stall_cnt = r_stall_cnt;
   assign bus.stat_fwd_cnt   = r_fwd_cnt;
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^w_fwd;
`endif
endmodule

// File: tb/tb_operand_bypass_unit.sv
// tb_operand_bypass_unit: scenario tasks with a scoreboard queue checked against the EX register
module tb_operand_bypass_unit;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NS = 2;
   localparam int DP = 2;
   typedef struct {
      logic           v;
      logic [NS*DW-1:0] op;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   always #5 clk = ~clk;
   operand_bypass_unit_if #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .DEPTH(DP)) bus ();
   operand_bypass_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .DEPTH(DP), .LOAD_STAGE(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   // scoreboard: one expectation per driven cycle, checked just after the edge that registers it
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (bus.ex_valid !== e.v) begin
            errors++;
            $display("FAIL ex_valid got=%0b exp=%0b t=%0t", bus.ex_valid, e.v, $time);
         end
         checks++;
         if (bus.ex_op !== e.op) begin
            errors++;
            $display("FAIL ex_op got=%h exp=%h t=%0t", bus.ex_op, e.op, $time);
         end
      end
   end
   task automatic drive(input logic v, input logic [AW-1:0] s0, s1, input logic [DW-1:0] d0, d1,
                        input logic [DW-1:0] imm, input logic asrc, input logic [AW-1:0] dst,
                        input logic we, ld, input logic [DW-1:0] w0, w1);
      bus.id_valid    = v;
      bus.id_src_addr = {s1, s0};
      bus.id_src_data = {d1, d0};
      bus.id_imm      = imm;
      bus.id_alusrc   = asrc;
      bus.id_dst_addr = dst;
      bus.id_dst_we   = we;
      bus.id_is_load  = ld;
      bus.stage_wdata = {w1, w0};
   endtask
   task automatic advance(input logic v, input logic [NS*DW-1:0] op);
      q.push_back('{v, op});
      @(posedge clk);
      #1;
   endtask
   task automatic bubble();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      advance(0, '0);
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      drive(1, 5, 5, 32'h11, 32'h22, 0, 0, 5, 1, 1, 32'h99, 32'h98);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.ex_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ex_valid got=%0b exp=0", bus.ex_valid);
      end
      checks++;
      if (bus.ex_op !== '0) begin
         errors++;
         $display("FAIL reset_ex_op got=%h exp=0", bus.ex_op);
      end
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall got=%b exp=0", bus.stall);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1, 5, 6, 32'h11, 32'h22, 0, 0, 7, 0, 0, 32'h99, 32'h98);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_stall got=%b exp=0", bus.stall);
      end
      advance(1, {32'h22, 32'h11});
   endtask
   task automatic test_alu_fwd();
      drive(1, 1, 2, 32'h11, 32'h22, 0, 0, 3, 1, 0, 0, 0);
      advance(1, {32'h22, 32'h11});
      drive(1, 3, 4, 32'hDEAD, 32'h44, 0, 0, 6, 1, 0, 32'h1234, 32'h5678);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL alu_fwd_stall got=%b exp=0", bus.stall);
      end
      advance(1, {32'h44, 32'h1234});
      bubble();
   endtask
   task automatic test_double_write();
      drive(1, 1, 2, 32'h1, 32'h2, 0, 0, 3, 1, 0, 0, 0);
      advance(1, {32'h2, 32'h1});
      drive(1, 7, 8, 32'h7, 32'h8, 0, 0, 3, 1, 0, 0, 0);
      advance(1, {32'h8, 32'h7});
      drive(1, 3, 3, 32'h33, 32'h33, 0, 0, 9, 0, 0, 32'hAAAA, 32'hBBBB);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL double_write_stall got=%b exp=0", bus.stall);
      end
      advance(1, {32'hAAAA, 32'hAAAA});
      bubble();
   endtask
   task automatic test_load_use();
      drive(1, 1, 2, 32'h1, 32'h2, 0, 0, 5, 1, 1, 0, 0);
      advance(1, {32'h2, 32'h1});
      drive(1, 9, 5, 32'h90, 32'h999, 0, 0, 10, 1, 0, 32'h5555, 32'h7777);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b1) begin
         errors++;
         $display("FAIL load_use_stall got=%b exp=1", bus.stall);
      end
      advance(0, '0);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL load_use_release got=%b exp=0", bus.stall);
      end
      advance(1, {32'h7777, 32'h90});
      bubble();
   endtask
   task automatic test_r0_imm();
      drive(1, 1, 2, 32'h1, 32'h2, 0, 0, 0, 1, 1, 0, 0);
      advance(1, {32'h2, 32'h1});
      drive(1, 0, 1, 32'h0, 32'h10, 0, 0, 4, 0, 0, 32'hFFFF, 32'hEEEE);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL r0_stall got=%b exp=0", bus.stall);
      end
      advance(1, {32'h10, 32'h0});
      drive(1, 1, 2, 32'h1, 32'h2, 0, 0, 5, 1, 1, 0, 0);
      advance(1, {32'h2, 32'h1});
      drive(1, 2, 5, 32'h22, 32'h55, 32'hCAFE, 1, 4, 0, 0, 32'h5151, 32'h6161);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL imm_stall got=%b exp=0", bus.stall);
      end
      advance(1, {32'hCAFE, 32'h22});
      bubble();
   endtask
   task automatic test_flush();
      drive(1, 1, 2, 32'h1, 32'h2, 0, 0, 5, 1, 1, 0, 0);
      advance(1, {32'h2, 32'h1});
      drive(1, 5, 6, 32'h50, 32'h60, 0, 0, 8, 1, 0, 32'hF0F0, 32'hE0E0);
      bus.flush = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_stall got=%b exp=1", bus.stall);
      end
      advance(0, '0);
      bus.flush = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL after_flush_stall got=%b exp=0", bus.stall);
      end
      advance(1, {32'h60, 32'h50});
      bubble();
   endtask
   initial begin
      bus.flush = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_alu_fwd();
      test_double_write();
      test_load_use();
      test_r0_imm();
      test_flush();
      @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
